// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator: operand/go/status/result
// registers on a 2-bit address bus around a multi-cycle n! core.
module fact_accel (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  A,
  input  logic        WE,
  input  logic [3:0]  WD,
  output logic [31:0] RD,
  output logic        Done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic        we1, we2, go_cmb;
  logic [3:0]  n_reg;
  logic        go_reg;
  logic        go_pulse;
  logic [31:0] result_reg;
  logic        res_done, res_err;
  logic        error;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] prod;

  assign we1    = WE & (A == 2'd0);
  assign we2    = WE & (A == 2'd1);
  assign go_cmb = we2 & WD[0];

  assign Done  = (state == DONE);
  assign error = (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg      <= '0;
      go_reg     <= 1'b0;
      go_pulse   <= 1'b0;
      result_reg <= '0;
      res_done   <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      if (we1) n_reg <= WD;
      if (we2) go_reg <= WD[0];
      go_pulse <= go_cmb;
      if (Done) result_reg <= prod;
      // A new go clears the sticky flags even if the core reports on the same edge.
      if (go_cmb)     res_done <= 1'b0;
      else if (Done)  res_done <= 1'b1;
      if (go_cmb)     res_err  <= 1'b0;
      else if (error) res_err  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      prod  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go_pulse) begin
            if (n_reg > 4'd12) begin
              state <= ERR;
            end else begin
              cnt   <= n_reg;
              prod  <= 32'd1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt > 4'd1) begin
            prod <= prod * {28'd0, cnt};
            cnt  <= cnt - 4'd1;
          end else begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    RD = '0;
    case (A)
      2'd0:    RD = {28'd0, n_reg};
      2'd1:    RD = {31'd0, go_reg};
      2'd2:    RD = {30'd0, res_err, res_done};
      default: RD = result_reg;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// Randomized self-checking bench for fact_accel against an abstract register/factorial model.
module tb_fact_accel;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  A;
  logic        WE;
  logic [3:0]  WD;
  logic [31:0] RD;
  logic        Done;

  int checks = 0;
  int errors = 0;

  logic [3:0]  m_n;
  logic        m_go, m_done, m_err;
  logic [31:0] m_res;

  fact_accel dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .WE  (WE),
    .WD  (WD),
    .RD  (RD),
    .Done(Done)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] fact(input int n);
    longint p = 1;
    for (int i = 2; i <= n; i++) p = p * i;
    return p[31:0];
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    case (a)
      0:       return {28'd0, m_n};
      1:       return {31'd0, m_go};
      2:       return {30'd0, m_err, m_done};
      default: return m_res;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_n = '0; m_go = 1'b0; m_done = 1'b0; m_err = 1'b0; m_res = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    A = a; WE = 1'b1; WD = d;
    tick();
    WE = 1'b0;
    if (a == 2'd0) m_n = d;
    if (a == 2'd1) begin
      m_go = d[0];
      if (d[0]) begin m_done = 1'b0; m_err = 1'b0; end
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    A = a;
    #1;
    d = RD;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; WE = 1'b0; A = '0; WD = '0;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_rd A=%0d: got %0d expected 0", a, d);
      end
    end
    checks++;
    if (Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", Done);
    end
  endtask

  task automatic run_fact(input logic [3:0] n);
    logic [31:0] d;
    int first, pulses, exp_lat;
    wr(2'd0, n);
    wr(2'd1, 4'd1);
    rd(2'd2, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL status_clear n=%0d: got %0d expected 0", n, d);
    end
    exp_lat = (n > 4'd12) ? 0 : ((n > 4'd1) ? int'(n) + 1 : 2);
    first = 0; pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (Done === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    if (n > 4'd12) m_err = 1'b1;
    else begin m_res = fact(int'(n)); m_done = 1'b1; end
    checks++;
    if (pulses !== ((n > 4'd12) ? 0 : 1)) begin
      errors++;
      $display("FAIL done_pulses n=%0d: got %0d expected %0d", n, pulses, (n > 4'd12) ? 0 : 1);
    end
    checks++;
    if (first !== exp_lat) begin
      errors++;
      $display("FAIL done_latency n=%0d: got %0d expected %0d", n, first, exp_lat);
    end
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      checks++;
      if (d !== exp_rd(a)) begin
        errors++;
        $display("FAIL run_rd n=%0d A=%0d: got %0d expected %0d", n, a, d, exp_rd(a));
      end
    end
  endtask

  task automatic test_go_zero();
    logic [31:0] d;
    int pulses = 0;
    wr(2'd1, 4'd0);
    for (int k = 0; k < 15; k++) begin
      tick();
      if (Done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL go_zero_done: got %0d expected 0", pulses);
    end
    for (int a = 1; a < 4; a++) begin
      rd(a[1:0], d);
      checks++;
      if (d !== exp_rd(a)) begin
        errors++;
        $display("FAIL go_zero_rd A=%0d: got %0d expected %0d", a, d, exp_rd(a));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int first = 0, pulses = 0;
    wr(2'd0, 4'd6);
    wr(2'd1, 4'd1);
    for (int k = 1; k <= 30; k++) begin
      if (k == 3) begin A = 2'd1; WE = 1'b1; WD = 4'd1; end
      else if (k == 4) begin A = 2'd0; WE = 1'b1; WD = 4'd2; end
      else WE = 1'b0;
      tick();
      if (Done === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    WE = 1'b0;
    m_go = 1'b1; m_n = 4'd2; m_res = 32'd720; m_done = 1'b1; m_err = 1'b0;
    checks++;
    if (pulses !== 1 || first !== 7) begin
      errors++;
      $display("FAIL midrun_done: got pulses=%0d at %0d expected 1 at 7", pulses, first);
    end
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      checks++;
      if (d !== exp_rd(a)) begin
        errors++;
        $display("FAIL midrun_rd A=%0d: got %0d expected %0d", a, d, exp_rd(a));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int pulses = 0;
    wr(2'd0, 4'd10);
    wr(2'd1, 4'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (Done === 1'b1) pulses++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 25; k++) begin
      tick();
      if (Done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_done: got %0d expected 0", pulses);
    end
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_mid_rd A=%0d: got %0d expected 0", a, d);
      end
    end
  endtask

  initial begin
    rst = 1'b1; WE = 1'b0; A = '0; WD = '0;
    model_reset();
    test_reset();
    run_fact(4'd5);
    run_fact(4'd12);
    run_fact(4'd0);
    run_fact(4'd5);
    run_fact(4'd13);
    test_go_zero();
    run_fact(4'd3);
    run_fact(4'd1);
    test_back_to_back();
    for (int i = 0; i < 8; i++) run_fact(4'($urandom_range(0, 15)));
    run_fact(4'd15);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
